// File: rtl/hazard_scheduler.sv
// hazard_scheduler: per-stage flush/stall, EX forwarding selects and data-memory sequencing for the 5-stage core.
// Optional feature macro HAZARD_STALL_CNT_EN adds a saturating 32-bit stall_cycles counter output.

package hazard_scheduler_pkg;
    typedef struct packed {
        logic flush;
        logic stall;
    } stage_ctrl_t;

    typedef struct packed {
        stage_ctrl_t fetch;    // PC register
        stage_ctrl_t decode;   // F/D register
        stage_ctrl_t execute;  // D/E register
        stage_ctrl_t memory;   // E/M register
    } hazard_data_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_ERR   = 2'd2
    } sched_state_e;
endpackage

module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [4:0]   d_rs,
    input  logic [4:0]   d_rt,
    input  logic [4:0]   e_rs,
    input  logic [4:0]   e_rt,
    input  logic [4:0]   e_write_reg,
    input  logic         e_mem_to_reg,
    input  logic [4:0]   m_write_reg,
    input  logic         m_reg_write,
    input  logic [4:0]   w_write_reg,
    input  logic         w_reg_write,
    input  logic         m_mem_read,
    input  logic         m_mem_write,
    input  logic         m_branch_taken,
    input  logic         d_jump,
    input  logic         imem_busy,
    input  logic         dresp_valid,
    output logic         dreq_valid,
    output hazard_data_t hazard,
    output logic [1:0]   forward_a,
    output logic [1:0]   forward_b,
    output logic         mem_err,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]  stall_cycles,
`endif
    output logic [1:0]   dbg_state
);

    // Data-memory handshake: dreq_valid rises when the MEM-stage access is issued and
    // stays high until the cycle dresp_valid is seen; that cycle completes the access.

    sched_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic redirect_q, redirect_d;

    hazard_data_t haz_raw;
    hazard_data_t haz_res;
    logic dreq_raw;
    logic mem_req;
    logic load_use;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign mem_req  = m_mem_read | m_mem_write;
    assign load_use = e_mem_to_reg && (e_write_reg != 5'd0) &&
                      ((e_write_reg == d_rs) || (e_write_reg == d_rt));

    // MEM result is younger than WB, so it takes priority.
    always_comb begin
        fwd_a_raw = 2'b00;
        if (m_reg_write && (m_write_reg != 5'd0) && (m_write_reg == e_rs)) begin
            fwd_a_raw = 2'b10;
        end else if (w_reg_write && (w_write_reg != 5'd0) && (w_write_reg == e_rs)) begin
            fwd_a_raw = 2'b01;
        end
    end

    always_comb begin
        fwd_b_raw = 2'b00;
        if (m_reg_write && (m_write_reg != 5'd0) && (m_write_reg == e_rt)) begin
            fwd_b_raw = 2'b10;
        end else if (w_reg_write && (w_write_reg != 5'd0) && (w_write_reg == e_rt)) begin
            fwd_b_raw = 2'b01;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = redirect_q;
        haz_raw    = '0;
        dreq_raw   = 1'b0;

        case (state_q)
            ST_RUN: begin
                dreq_raw = mem_req;
                if (mem_req && !dresp_valid) begin
                    haz_raw.fetch.stall   = 1'b1;
                    haz_raw.decode.stall  = 1'b1;
                    haz_raw.execute.stall = 1'b1;
                    haz_raw.memory.stall  = 1'b1;
                    state_d = ST_DWAIT;
                    cnt_d   = '0;
                end else begin
                    if (m_branch_taken) begin
                        haz_raw.decode.flush  = 1'b1;
                        haz_raw.execute.flush = 1'b1;
                        haz_raw.memory.flush  = 1'b1;
                        if (imem_busy) begin
                            redirect_d = 1'b1;
                        end
                    end else if (load_use) begin
                        haz_raw.fetch.stall   = 1'b1;
                        haz_raw.decode.stall  = 1'b1;
                        haz_raw.execute.flush = 1'b1;
                    end else if (d_jump) begin
                        haz_raw.decode.flush = 1'b1;
                    end else if (imem_busy) begin
                        haz_raw.fetch.stall  = 1'b1;
                        haz_raw.decode.flush = 1'b1;
                    end
                    // The word fetched while the redirect was pending is from the wrong path.
                    if (redirect_q && !imem_busy) begin
                        haz_raw.fetch.flush = 1'b1;
                        redirect_d = 1'b0;
                    end
                end
            end
            ST_DWAIT: begin
                dreq_raw = 1'b1;
                haz_raw.fetch.stall   = 1'b1;
                haz_raw.decode.stall  = 1'b1;
                haz_raw.execute.stall = 1'b1;
                haz_raw.memory.stall  = 1'b1;
                if (dresp_valid) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                haz_raw.fetch.stall   = 1'b1;
                haz_raw.decode.stall  = 1'b1;
                haz_raw.execute.stall = 1'b1;
                haz_raw.memory.stall  = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // A flushed stage must not also hold its stale contents.
    always_comb begin
        haz_res = haz_raw;
        haz_res.fetch.stall   = haz_raw.fetch.stall   & ~haz_raw.fetch.flush;
        haz_res.decode.stall  = haz_raw.decode.stall  & ~haz_raw.decode.flush;
        haz_res.execute.stall = haz_raw.execute.stall & ~haz_raw.execute.flush;
        haz_res.memory.stall  = haz_raw.memory.stall  & ~haz_raw.memory.flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
        end
    end

    assign hazard     = reset_n ? haz_res   : '0;
    assign dreq_valid = reset_n ? dreq_raw  : 1'b0;
    assign forward_a  = reset_n ? fwd_a_raw : 2'b00;
    assign forward_b  = reset_n ? fwd_b_raw : 2'b00;
    assign mem_err    = (state_q == ST_ERR);
    assign dbg_state  = state_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic any_stall;

    assign any_stall = haz_res.fetch.stall | haz_res.decode.stall |
                       haz_res.execute.stall | haz_res.memory.stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (any_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed plan scenarios plus random traffic, all scored
// against a behavioural model through an expected-response queue.
`timescale 1ns/1ps

module tb_hazard_scheduler;

    localparam int MAX_WAIT = 4;
`ifdef HAZARD_STALL_CNT_EN
    localparam int W = 46;
`else
    localparam int W = 14;
`endif
    localparam int MD_RUN  = 0;
    localparam int MD_WAIT = 1;
    localparam int MD_ERR  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_write_reg, m_write_reg, w_write_reg;
    logic e_mem_to_reg, m_reg_write, w_reg_write, m_mem_read, m_mem_write;
    logic m_branch_taken, d_jump, imem_busy, dresp_valid;
    logic dreq_valid, mem_err;
    logic [1:0] forward_a, forward_b, dbg_state;
    hazard_scheduler_pkg::hazard_data_t hazard;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    hazard_scheduler #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .d_rs(d_rs), .d_rt(d_rt), .e_rs(e_rs), .e_rt(e_rt),
        .e_write_reg(e_write_reg), .e_mem_to_reg(e_mem_to_reg),
        .m_write_reg(m_write_reg), .m_reg_write(m_reg_write),
        .w_write_reg(w_write_reg), .w_reg_write(w_reg_write),
        .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
        .m_branch_taken(m_branch_taken), .d_jump(d_jump),
        .imem_busy(imem_busy), .dresp_valid(dresp_valid),
        .dreq_valid(dreq_valid), .hazard(hazard),
        .forward_a(forward_a), .forward_b(forward_b), .mem_err(mem_err),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check_now(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
`ifdef HAZARD_STALL_CNT_EN
            mon_got = {stall_cycles, hazard, dreq_valid, forward_a, forward_b, mem_err};
`else
            mon_got = {hazard, dreq_valid, forward_a, forward_b, mem_err};
`endif
            check_now("scoreboard", 64'(mon_got), 64'(mon_exp));
        end
    end

    // ---------------- reference model ----------------
    int md = MD_RUN;
    int waited = 0;
    bit pending = 1'b0;
    logic [31:0] sc = '0;

    function automatic logic [1:0] fwd_ref(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (m_reg_write && m_write_reg == r) return 2'b10;
        if (w_reg_write && w_write_reg == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic expect_cycle();
        bit fl[4];
        bit st[4];
        bit any;
        logic [7:0] hz;
        logic dq, me;
        logic [1:0] fa, fb;
        logic [31:0] sc_now;
        logic [W-1:0] e;
        for (int i = 0; i < 4; i++) begin
            fl[i] = 1'b0;
            st[i] = 1'b0;
        end
        dq = 1'b0;
        if (!reset_n) begin
            md = MD_RUN;
            waited = 0;
            pending = 1'b0;
            sc = '0;
            exp_q.push_back('0);
            return;
        end
        me = (md == MD_ERR);
        fa = fwd_ref(e_rs);
        fb = fwd_ref(e_rt);
        if (md == MD_ERR) begin
            for (int i = 0; i < 4; i++) st[i] = 1'b1;
        end else if (md == MD_WAIT) begin
            dq = 1'b1;
            for (int i = 0; i < 4; i++) st[i] = 1'b1;
            if (dresp_valid) md = MD_RUN;
            else begin
                waited++;
                if (waited == MAX_WAIT) md = MD_ERR;
            end
        end else begin
            dq = m_mem_read | m_mem_write;
            if (dq && !dresp_valid) begin
                for (int i = 0; i < 4; i++) st[i] = 1'b1;
                md = MD_WAIT;
                waited = 0;
            end else begin
                if (pending && !imem_busy) begin
                    fl[0] = 1'b1;
                    pending = 1'b0;
                end
                if (m_branch_taken) begin
                    fl[1] = 1'b1; fl[2] = 1'b1; fl[3] = 1'b1;
                    if (imem_busy) pending = 1'b1;
                end else if (e_mem_to_reg && e_write_reg != 0 &&
                             (e_write_reg == d_rs || e_write_reg == d_rt)) begin
                    st[0] = 1'b1; st[1] = 1'b1; fl[2] = 1'b1;
                end else if (d_jump) begin
                    fl[1] = 1'b1;
                end else if (imem_busy) begin
                    st[0] = 1'b1; fl[1] = 1'b1;
                end
            end
        end
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fl[i]) st[i] = 1'b0;
            any |= st[i];
        end
        hz = {fl[0], st[0], fl[1], st[1], fl[2], st[2], fl[3], st[3]};
        sc_now = sc;
        if (any && sc != 32'hFFFF_FFFF) sc = sc + 1;
`ifdef HAZARD_STALL_CNT_EN
        e = {sc_now, hz, dq, fa, fb, me};
`else
        e = {hz, dq, fa, fb, me};
        if (sc_now == 32'hFFFF_FFFF) e = e;
`endif
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = 0; d_rt = 0; e_rs = 0; e_rt = 0; e_write_reg = 0; m_write_reg = 0; w_write_reg = 0;
        e_mem_to_reg = 0; m_reg_write = 0; w_reg_write = 0; m_mem_read = 0; m_mem_write = 0;
        m_branch_taken = 0; d_jump = 0; imem_busy = 0; dresp_valid = 0;
    endtask

    task automatic do_reset();
        next_cycle(); idle(); reset_n = 1'b0; expect_cycle();
        #1 check_now("reset_hazard", 64'(hazard), 64'h0);
        next_cycle(); reset_n = 1'b1; expect_cycle();
    endtask

    task automatic randomize_inputs();
        d_rs = 5'($urandom_range(0, 7)); d_rt = 5'($urandom_range(0, 7));
        e_rs = 5'($urandom_range(0, 7)); e_rt = 5'($urandom_range(0, 7));
        e_write_reg = 5'($urandom_range(0, 7));
        m_write_reg = 5'($urandom_range(0, 7));
        w_write_reg = 5'($urandom_range(0, 7));
        e_mem_to_reg = ($urandom_range(0, 3) == 0);
        m_reg_write = $urandom_range(0, 1); w_reg_write = $urandom_range(0, 1);
        m_mem_read = ($urandom_range(0, 5) == 0); m_mem_write = ($urandom_range(0, 7) == 0);
        m_branch_taken = ($urandom_range(0, 6) == 0); d_jump = ($urandom_range(0, 6) == 0);
        imem_busy = ($urandom_range(0, 2) == 0); dresp_valid = ($urandom_range(0, 2) != 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        do_reset();

        // forwarding priority
        next_cycle(); idle();
        m_reg_write = 1; w_reg_write = 1; m_write_reg = 5; w_write_reg = 5; e_rs = 5;
        expect_cycle();
        #1 check_now("fwd_mem_priority", 64'(forward_a), 64'h2);
        next_cycle(); m_write_reg = 0; expect_cycle();
        #1 check_now("fwd_wb", 64'(forward_a), 64'h1);

        // load-use
        next_cycle(); idle(); e_mem_to_reg = 1; e_write_reg = 8; d_rt = 8; expect_cycle();
        #1 check_now("load_use", 64'(hazard), 64'h58);
        next_cycle(); e_write_reg = 0; d_rt = 0; expect_cycle();
        #1 check_now("load_use_r0", 64'(hazard), 64'h0);
        next_cycle(); idle(); expect_cycle();
        #1 check_now("load_use_gone", 64'(hazard), 64'h0);

        // memory wait: three cycles without response
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle(); idle(); m_mem_read = 1; dresp_valid = (i == 3); expect_cycle();
            #1 check_now("mwait_stall", 64'({hazard, dreq_valid}), 64'h0AB);
        end
        next_cycle(); idle(); expect_cycle();
        #1 check_now("mwait_run", 64'({dbg_state, hazard}), 64'h0);
`ifdef HAZARD_STALL_CNT_EN
        check_now("mwait_stall_cycles", 64'(stall_cycles), 64'd4);
`endif

        // watchdog
        for (int i = 0; i < 5; i++) begin
            next_cycle(); idle(); m_mem_read = 1; expect_cycle();
            #1 check_now("wdog_pre_err", 64'(mem_err), 64'h0);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle(); idle(); m_mem_read = 1; dresp_valid = (i == 1); expect_cycle();
            #1 check_now("wdog_err", 64'({mem_err, dreq_valid, hazard}), 64'h255);
        end
        do_reset();
        #1 check_now("wdog_cleared", 64'(mem_err), 64'h0);

        // branch while fetch busy
        next_cycle(); idle(); m_branch_taken = 1; imem_busy = 1; expect_cycle();
        #1 check_now("branch_flush", 64'(hazard), 64'h2A);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); idle(); imem_busy = 1; expect_cycle();
            #1 check_now("ibusy_stall", 64'(hazard), 64'h60);
        end
        next_cycle(); idle(); expect_cycle();
        #1 check_now("redirect_flush", 64'(hazard), 64'h80);
        next_cycle(); idle(); expect_cycle();
        #1 check_now("redirect_once", 64'(hazard), 64'h0);

        // asynchronous reset in DWAIT
        next_cycle(); idle(); m_mem_read = 1; expect_cycle();
        next_cycle(); expect_cycle();
        #1 check_now("dwait_dreq", 64'(dreq_valid), 64'h1);
        next_cycle(); reset_n = 1'b0; expect_cycle();
        #1 check_now("async_rst", 64'({hazard, dreq_valid}), 64'h0);
        next_cycle(); reset_n = 1'b1; idle(); m_mem_write = 1; dresp_valid = 1; expect_cycle();
        #1 check_now("zero_latency", 64'({hazard, dreq_valid}), 64'h1);
        next_cycle(); idle(); expect_cycle();
        #1 check_now("zero_latency_run", 64'(dbg_state), 64'h0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            next_cycle();
            randomize_inputs();
            reset_n = !((md == MD_ERR && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0);
            expect_cycle();
        end

        next_cycle(); reset_n = 1'b1; idle(); expect_cycle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
